traffic_phase_controller: RTL and testbench

Parametrised N-way traffic phase controller. It is the next-generation signal sequencer for an intersection and replaces the fixed 4-way, 3-bit-state design. Direction count and green/yellow/all-red durations are set by parameters. It adds a mandatory all-red clearance interval, minimum-green protection, empty-approach skipping and round-robin fairness. Timing is driven by an external `tick` strobe, so the block sits between the intersection sensor front-end and the lamp driver.

---
 rtl/traffic_phase_controller.sv | 144 ++++++++++++++
 tb/tb_traffic_phase_controller.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_controller.sv
// N-way traffic phase sequencer: GREEN -> YELLOW -> ALL_RED with emergency preemption,
// congestion priority, minimum-green protection and round-robin skipping of empty approaches.
module traffic_phase_controller #(
  parameter int NUM_DIR     = 4,
  parameter int GREEN_MAX   = 10,
  parameter int GREEN_MIN   = 3,
  parameter int YELLOW_TIME = 4,
  parameter int ALLRED_TIME = 1,
  parameter int CNT_W       = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic [NUM_DIR-1:0]         emergency,
  input  logic [NUM_DIR-1:0]         jam,
  input  logic [NUM_DIR-1:0]         empty,
  output logic [3*NUM_DIR-1:0]       lights,
  output logic [$clog2(NUM_DIR)-1:0] active_dir,
  output logic [1:0]                 phase,
  output logic                       preempted
);

  localparam int AW = $clog2(NUM_DIR);
  localparam logic [CNT_W-1:0] G_LAST  = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] G_MIN_L = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALLRED_TIME - 1);

  // Encoding doubles as the phase output code.
  typedef enum logic [1:0] {
    GREEN   = 2'b00,
    YELLOW  = 2'b01,
    ALL_RED = 2'b10
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [AW-1:0]    dir_n, pick_dir;
  logic             pre_n;
  logic [NUM_DIR-1:0] dir_mask;
  logic             own_emg, other_emg, own_jam, other_jam, own_empty;

  assign dir_mask  = NUM_DIR'(1) << active_dir;
  assign own_emg   = emergency[active_dir];
  assign other_emg = |(emergency & ~dir_mask);
  assign own_jam   = jam[active_dir];
  assign other_jam = |(jam & ~dir_mask);
  assign own_empty = empty[active_dir];

  // Next-green selection; lower-priority rules are written first so higher ones override.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    pick_dir = AW'((int'(active_dir) + 1) % NUM_DIR);
    for (int k = NUM_DIR; k >= 1; k--) begin
      if (!empty[AW'((int'(active_dir) + k) % NUM_DIR)])
        pick_dir = AW'((int'(active_dir) + k) % NUM_DIR);
    end
    for (int i = NUM_DIR - 1; i >= 0; i--) begin
      if (jam[AW'(i)] && !(|emergency)) pick_dir = AW'(i);
    end
    for (int i = NUM_DIR - 1; i >= 0; i--) begin
      if (emergency[AW'(i)]) pick_dir = AW'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ALL_RED;
      cnt        <= '0;
      active_dir <= AW'(NUM_DIR - 1);
      preempted  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all state registers update from pre-edge values.
      state      <= state_n;
      cnt        <= cnt_n;
      active_dir <= dir_n;
      preempted  <= pre_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dir_n   = active_dir;
    pre_n   = preempted;
    unique case (state)
      GREEN: begin
        if (own_emg) begin
          cnt_n = '0;
        end else if (other_emg) begin
          state_n = YELLOW;
          cnt_n   = '0;
        end else if (tick) begin
          if (cnt == G_LAST ||
              (cnt >= G_MIN_L && ((own_empty && !own_jam) || other_jam))) begin
            state_n = YELLOW;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      YELLOW: begin
        if (tick) begin
          if (cnt == Y_LAST) begin
            state_n = ALL_RED;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      ALL_RED: begin
        if (tick) begin
          if (cnt == AR_LAST) begin
            state_n = GREEN;
            cnt_n   = '0;
            dir_n   = pick_dir;
            pre_n   = |emergency;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = ALL_RED;
        cnt_n   = '0;
      end
    endcase
  end

  // Lamp decode straight from the state registers; only the active approach can be non-red.
  always_comb begin
    phase  = state;
    lights = {NUM_DIR{3'b100}};
    for (int i = 0; i < NUM_DIR; i++) begin
      if (active_dir == AW'(i)) begin
        if (state == GREEN)       lights[3*i +: 3] = 3'b001;
        else if (state == YELLOW) lights[3*i +: 3] = 3'b010;
      end
    end
  end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Bench for traffic_phase_controller: directed scenarios plus randomized traffic checked
// against a rule-level reference model of the intersection.
module tb_traffic_phase_controller;

  localparam int ND = 4;
  localparam int GMAX = 10, GMIN = 3, YT = 4, ART = 1;

  logic          clk, rst, tick;
  logic [ND-1:0] emergency, jam, empty;
  logic [3*ND-1:0] lights;
  logic [1:0]    active_dir, phase;
  logic          preempted;
  logic [16:0]   got;

  int n_checks = 0, n_errors = 0;
  int m_ph, m_el, m_dir;
  logic m_pre;
  int tmode = 0, cyc = 0;

  traffic_phase_controller dut (
    .clk(clk), .rst(rst), .tick(tick), .emergency(emergency), .jam(jam), .empty(empty),
    .lights(lights), .active_dir(active_dir), .phase(phase), .preempted(preempted)
  );

  assign got = {lights, phase, active_dir, preempted};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [11:0] lamp(int ph, int dir);
    logic [11:0] v;
    v = 12'h924;
    if (ph == 0) v[3*dir +: 3] = 3'b001;
    else if (ph == 1) v[3*dir +: 3] = 3'b010;
    return v;
  endfunction

  function automatic logic [16:0] exp_vec();
    return {lamp(m_ph, m_dir), 2'(m_ph), 2'(m_dir), m_pre};
  endfunction

  task automatic model_reset();
    m_ph = 2; m_el = 0; m_dir = ND - 1; m_pre = 1'b0;
  endtask

  // Intersection rules, phase 0 green / 1 yellow / 2 all-red, m_el = ticks spent in phase.
  task automatic model_step();
    int nd;
    bit found;
    if (rst) begin
      model_reset();
      return;
    end
    case (m_ph)
      0: begin
        if (emergency[m_dir]) m_el = 0;
        else if ((emergency & ~4'(1 << m_dir)) != 0) begin m_ph = 1; m_el = 0; end
        else if (tick) begin
          if (m_el == GMAX - 1 ||
              (m_el >= GMIN - 1 &&
               ((empty[m_dir] && !jam[m_dir]) || (jam & ~4'(1 << m_dir)) != 0))) begin
            m_ph = 1; m_el = 0;
          end else m_el++;
        end
      end
      1: if (tick) begin
        if (m_el == YT - 1) begin m_ph = 2; m_el = 0; end else m_el++;
      end
      default: if (tick) begin
        if (m_el == ART - 1) begin
          nd = (m_dir + 1) % ND;
          found = 0;
          if (emergency != 0) begin
            for (int i = ND - 1; i >= 0; i--) if (emergency[i]) nd = i;
          end else if (jam != 0) begin
            for (int i = ND - 1; i >= 0; i--) if (jam[i]) nd = i;
          end else begin
            for (int k = 1; k <= ND; k++)
              if (!found && !empty[(m_dir + k) % ND]) begin nd = (m_dir + k) % ND; found = 1; end
          end
          m_pre = (emergency != 0);
          m_dir = nd; m_ph = 0; m_el = 0;
        end else m_el++;
      end
    endcase
  endtask

  // One clock: choose tick, let the edge happen, advance the model, settle past the edge.
  task automatic cycle();
    case (tmode)
      0: tick = 1'b1;
      1: tick = (cyc % 4 == 3);
      default: tick = 1'($urandom_range(0, 1));
    endcase
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; emergency = '0; jam = '0; empty = '0;
    model_reset();
    cycle(); cycle();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b1; emergency = '0; jam = '0; empty = '0;
    model_reset();
    #3;
    n_checks++; if (lights !== 12'h924) begin n_errors++; $display("FAIL reset_lights got=%h exp=924", lights); end
    n_checks++; if (phase !== 2'b10) begin n_errors++; $display("FAIL reset_phase got=%b exp=10", phase); end
    n_checks++; if (active_dir !== 2'd3) begin n_errors++; $display("FAIL reset_dir got=%0d exp=3", active_dir); end
    n_checks++; if (preempted !== 1'b0) begin n_errors++; $display("FAIL reset_preempted got=%b exp=0", preempted); end
  endtask

  task automatic test_free_run();
    tmode = 0;
    do_reset();
    for (int e = 1; e <= 61; e++) begin
      cycle();
      n_checks++;
      if (got !== exp_vec()) begin n_errors++; $display("FAIL free_model edge=%0d got=%h exp=%h", e, got, exp_vec()); end
      if (e == 1 || e == 61) begin
        n_checks++; if (lights !== 12'h921) begin n_errors++; $display("FAIL free_dir0_green edge=%0d got=%h exp=921", e, lights); end
      end
      if (e == 11) begin
        n_checks++; if (lights !== 12'h922) begin n_errors++; $display("FAIL free_yellow got=%h exp=922", lights); end
      end
      if (e == 15) begin
        n_checks++; if (phase !== 2'b10) begin n_errors++; $display("FAIL free_allred got=%b exp=10", phase); end
      end
      if (e == 16) begin
        n_checks++; if (lights !== 12'h90C || active_dir !== 2'd1) begin n_errors++; $display("FAIL free_dir1_green got=%h/%0d exp=90c/1", lights, active_dir); end
      end
    end
  endtask

  task automatic test_empty_skip();
    tmode = 0;
    do_reset();
    for (int e = 1; e <= 47; e++) begin
      cycle();
      if (e == 1) empty = 4'b0001;
      if (e == 9) begin
        n_checks++; if (active_dir !== 2'd1 || phase !== 2'b00) begin n_errors++; $display("FAIL empty_next_dir1 got=%0d/%b exp=1/00", active_dir, phase); end
        empty = 4'b0110;
      end
      n_checks++;
      if (got !== exp_vec()) begin n_errors++; $display("FAIL empty_model edge=%0d got=%h exp=%h", e, got, exp_vec()); end
      if (e == 4 || e == 12) begin
        n_checks++; if (phase !== 2'b01) begin n_errors++; $display("FAIL empty_min_green edge=%0d got=%b exp=01", e, phase); end
      end
      if (e == 17 || e == 47) begin
        n_checks++; if (lights !== 12'h324) begin n_errors++; $display("FAIL empty_skip_to_dir3 edge=%0d got=%h exp=324", e, lights); end
      end
      if (e == 32) begin
        n_checks++; if (lights !== 12'h921) begin n_errors++; $display("FAIL empty_dir0 got=%h exp=921", lights); end
      end
    end
    empty = '0;
  endtask

  task automatic test_emergency();
    tmode = 0;
    do_reset();
    cycle(); cycle();
    emergency = 4'b0100;
    cycle();
    n_checks++; if (lights !== 12'h922) begin n_errors++; $display("FAIL emg_yellow_1clk got=%h exp=922", lights); end
    for (int e = 4; e <= 8; e++) begin
      cycle();
      n_checks++;
      if (got !== exp_vec()) begin n_errors++; $display("FAIL emg_model edge=%0d got=%h exp=%h", e, got, exp_vec()); end
    end
    n_checks++; if (lights !== 12'h864 || preempted !== 1'b1) begin n_errors++; $display("FAIL emg_dir2_green got=%h/%b exp=864/1", lights, preempted); end
    for (int e = 0; e < 15; e++) begin
      cycle();
      n_checks++; if (lights !== 12'h864) begin n_errors++; $display("FAIL emg_hold cyc=%0d got=%h exp=864", e, lights); end
    end
    emergency = '0;
    for (int e = 1; e <= 15; e++) begin
      cycle();
      n_checks++;
      if (got !== exp_vec()) begin n_errors++; $display("FAIL emg_release_model edge=%0d got=%h exp=%h", e, got, exp_vec()); end
      if (e == 9) begin
        n_checks++; if (phase !== 2'b00) begin n_errors++; $display("FAIL emg_green_length got=%b exp=00", phase); end
      end
      if (e == 10) begin
        n_checks++; if (phase !== 2'b01 || preempted !== 1'b1) begin n_errors++; $display("FAIL emg_release_yellow got=%b/%b exp=01/1", phase, preempted); end
      end
      if (e == 15) begin
        n_checks++; if (lights !== 12'h324 || preempted !== 1'b0) begin n_errors++; $display("FAIL emg_next_rr got=%h/%b exp=324/0", lights, preempted); end
      end
    end
  endtask

  task automatic test_jam();
    tmode = 0;
    do_reset();
    cycle();
    jam = 4'b1000;
    for (int e = 2; e <= 9; e++) begin
      cycle();
      n_checks++;
      if (got !== exp_vec()) begin n_errors++; $display("FAIL jam_model edge=%0d got=%h exp=%h", e, got, exp_vec()); end
      if (e == 3) begin
        n_checks++; if (phase !== 2'b00) begin n_errors++; $display("FAIL jam_min_green got=%b exp=00", phase); end
      end
      if (e == 4) begin
        n_checks++; if (phase !== 2'b01) begin n_errors++; $display("FAIL jam_early_exit got=%b exp=01", phase); end
      end
    end
    n_checks++; if (lights !== 12'h324) begin n_errors++; $display("FAIL jam_next_dir3 got=%h exp=324", lights); end
    jam = '0;
  endtask

  task automatic test_slow_tick();
    int start, span;
    tmode = 1;
    do_reset();
    start = -1; span = -1;
    for (int e = 1; e <= 100 && span < 0; e++) begin
      cycle();
      n_checks++;
      if (got !== exp_vec()) begin n_errors++; $display("FAIL slow_model edge=%0d got=%h exp=%h", e, got, exp_vec()); end
      if (start < 0 && phase == 2'b00) start = e;
      if (start >= 0 && phase == 2'b01) span = e - start;
    end
    n_checks++; if (span !== 40) begin n_errors++; $display("FAIL slow_green_span got=%0d exp=40", span); end
    for (int e = 0; e < 100 && !(phase == 2'b00 && active_dir == 2'd1 && cyc % 4 != 3); e++) cycle();
    n_checks++; if (phase !== 2'b00 || active_dir !== 2'd1) begin n_errors++; $display("FAIL slow_reach_dir1 got=%b/%0d exp=00/1", phase, active_dir); end
    emergency = 4'b0001;
    cycle();
    n_checks++; if (phase !== 2'b01 || tick !== 1'b0) begin n_errors++; $display("FAIL slow_emg_1clk got=%b tick=%b exp=01 tick=0", phase, tick); end
    for (int e = 0; e < 100 && !(phase == 2'b00 && active_dir == 2'd0); e++) begin
      cycle();
      n_checks++;
      if (got !== exp_vec()) begin n_errors++; $display("FAIL slow_emg_model got=%h exp=%h", got, exp_vec()); end
    end
    n_checks++; if (lights !== 12'h921 || preempted !== 1'b1) begin n_errors++; $display("FAIL slow_emg_green got=%h/%b exp=921/1", lights, preempted); end
    emergency = '0;
    tmode = 0;
  endtask

  task automatic test_async_reset();
    tmode = 0;
    do_reset();
    for (int e = 1; e <= 12; e++) cycle();
    n_checks++; if (lights !== 12'h922) begin n_errors++; $display("FAIL areset_pre_yellow got=%h exp=922", lights); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (lights !== 12'h924) begin n_errors++; $display("FAIL areset_lights got=%h exp=924", lights); end
    n_checks++; if (phase !== 2'b10 || active_dir !== 2'd3) begin n_errors++; $display("FAIL areset_state got=%b/%0d exp=10/3", phase, active_dir); end
    model_reset();
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    n_checks++; if (lights !== 12'h921 || active_dir !== 2'd0) begin n_errors++; $display("FAIL areset_restart got=%h/%0d exp=921/0", lights, active_dir); end
  endtask

  task automatic test_random();
    int nonred;
    tmode = 2;
    do_reset();
    for (int e = 0; e < 3000; e++) begin
      if ($urandom_range(0, 39) == 0) emergency = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) jam = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      if ($urandom_range(0, 4) == 0) empty = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 599) == 0);
      cycle();
      n_checks++;
      if (got !== exp_vec()) begin n_errors++; $display("FAIL rand_model cyc=%0d got=%h exp=%h", e, got, exp_vec()); end
      nonred = 0;
      for (int i = 0; i < ND; i++) if (lights[3*i +: 3] != 3'b100) nonred++;
      n_checks++;
      if (nonred > 1) begin n_errors++; $display("FAIL rand_one_nonred cyc=%0d got=%0d exp<=1", e, nonred); end
    end
    rst = 1'b0;
    tmode = 0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_empty_skip();
    test_emergency();
    test_jam();
    test_slow_tick();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
